// File: rtl/lzw_conflict_table.sv
// LZW conflict table: small fully-associative store of relocated strings.
// Ports: clk, rst (async, active-low), cs, we, data, hash_in -> match,
// hash_out, ct_full (all outputs registered, one-clock lookup latency).
module lzw_conflict_table #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 64,
  parameter int HASH_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [HASH_WIDTH-1:0] hash_in,
  output logic                  match,
  output logic [HASH_WIDTH-1:0] hash_out,
  output logic                  ct_full
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]      valid;
  logic [DATA_WIDTH-1:0] key  [DEPTH];
  logic [HASH_WIDTH-1:0] hval [DEPTH];

  logic [CW-1:0] wptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic [DEPTH-1:0]      hit_vec;
  logic [DEPTH-1:0]      first_hit;
  logic [DEPTH-1:0]      new_we;
  logic [HASH_WIDTH-1:0] hit_hash;
  logic                  seen;
  logic                  hit;
  logic                  full_now;
  logic                  do_wr;
  logic                  do_upd;
  logic                  do_new;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = valid[i] && (key[i] == data);
    end
  end

  // Lowest-index hit wins both the read mux and the in-place update.
  always_comb begin
    first_hit = '0;
    hit_hash  = '0;
    seen      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_vec[i] && !seen) begin
        first_hit[i] = 1'b1;
        hit_hash     = hval[i];
        seen         = 1'b1;
      end
    end
  end

  assign hit      = |hit_vec;
  assign full_now = (count == CW'(DEPTH));
  assign do_wr    = cs & we;
  assign do_upd   = do_wr & hit;
  assign do_new   = do_wr & ~hit & ~full_now;

  always_comb begin
    new_we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      new_we[i] = do_new && (wptr == CW'(i));
    end
  end

  assign count_nxt = do_new ? count + 1'b1 : count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= '0;
      wptr     <= '0;
      count    <= '0;
      match    <= 1'b0;
      hash_out <= '0;
      ct_full  <= 1'b0;
    end else begin
      valid   <= valid | new_we;
      count   <= count_nxt;
      ct_full <= (count_nxt == CW'(DEPTH));
      if (do_new) begin
        wptr <= wptr + 1'b1;
      end
      match <= cs & hit;
      if (cs && hit) begin
        hash_out <= hit_hash;
      end
    end
  end

  // Payload needs no reset: an entry is only visible through its valid bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (new_we[i]) begin
        key[i]  <= data;
        hval[i] <= hash_in;
      end else if (do_upd && first_hit[i]) begin
        hval[i] <= hash_in;
      end
    end
  end

endmodule

// File: tb/tb_lzw_conflict_table.sv
// Self-checking bench for lzw_conflict_table.
// Table vectors plus hand sequences, checked through an expectation queue.
module tb_lzw_conflict_table;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        we;
  logic [63:0] data;
  logic [11:0] hash_in;
  logic        match;
  logic [11:0] hash_out;
  logic        ct_full;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        cs;
    logic        we;
    logic [63:0] data;
    logic [11:0] hin;
    logic        m;
    logic [11:0] h;
    logic        f;
  } vec_t;

  typedef struct {
    logic        m;
    logic [11:0] h;
    logic        f;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[9];

  lzw_conflict_table #(
    .DEPTH(8),
    .DATA_WIDTH(64),
    .HASH_WIDTH(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cs(cs),
    .we(we),
    .data(data),
    .hash_in(hash_in),
    .match(match),
    .hash_out(hash_out),
    .ct_full(ct_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive on falling edge, push expectation, compare just after rising edge.
  task automatic step(input string name, input logic c, input logic w,
                      input logic [63:0] d, input logic [11:0] hi,
                      input logic em, input logic [11:0] eh,
                      input logic ef);
    exp_t e;
    @(negedge clk);
    cs      = c;
    we      = w;
    data    = d;
    hash_in = hi;
    sb.push_back('{m: em, h: eh, f: ef});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".match"}, {63'd0, match}, {63'd0, e.m});
      chk({name, ".hash"}, {52'd0, hash_out}, {52'd0, e.h});
      chk({name, ".full"}, {63'd0, ct_full}, {63'd0, e.f});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    cs      = 1'b0;
    we      = 1'b0;
    data    = '0;
    hash_in = '0;
    #3;
    chk("rst.match", {63'd0, match}, 64'd0);
    chk("rst.hash", {52'd0, hash_out}, 64'd0);
    chk("rst.full", {63'd0, ct_full}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    tbl[0] = '{1'b1, 1'b0, 64'h41,   12'h000, 1'b0, 12'h000, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 64'h4142, 12'h1A3, 1'b0, 12'h000, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 64'h4142, 12'h000, 1'b1, 12'h1A3, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 64'h4143, 12'h000, 1'b0, 12'h1A3, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 64'h4142, 12'h2B0, 1'b1, 12'h1A3, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 64'h4142, 12'h000, 1'b1, 12'h2B0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 64'h0,    12'h055, 1'b0, 12'h2B0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 64'h0,    12'h000, 1'b1, 12'h055, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 64'h0,    12'h000, 1'b0, 12'h055, 1'b0};

    for (int i = 0; i < 9; i++) begin
      step($sformatf("vec%0d", i), tbl[i].cs, tbl[i].we, tbl[i].data,
           tbl[i].hin, tbl[i].m, tbl[i].h, tbl[i].f);
    end

    // Fill from empty: full flag rises on the eighth new key.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step($sformatf("fill%0d", i), 1'b1, 1'b1, 64'h1000 + 64'(i),
           12'h100 + 12'(i), 1'b0, 12'h000, (i == 7));
    end
    step("drop9", 1'b1, 1'b1, 64'h2000, 12'h1FF, 1'b0, 12'h000, 1'b1);
    step("look9", 1'b1, 1'b0, 64'h2000, 12'h000, 1'b0, 12'h000, 1'b1);
    step("look_k7", 1'b1, 1'b0, 64'h1007, 12'h000, 1'b1, 12'h107, 1'b1);
    step("look_k0", 1'b1, 1'b0, 64'h1000, 12'h000, 1'b1, 12'h100, 1'b1);
    step("upd_k3", 1'b1, 1'b1, 64'h1003, 12'h1EE, 1'b1, 12'h103, 1'b1);
    step("look_k3", 1'b1, 1'b0, 64'h1003, 12'h000, 1'b1, 12'h1EE, 1'b1);
    step("we_nocs", 1'b0, 1'b1, 64'h3000, 12'h0AA, 1'b0, 12'h1EE, 1'b1);
    step("look_nocs", 1'b1, 1'b0, 64'h3000, 12'h000, 1'b0, 12'h1EE, 1'b1);

    // Non-full table: cs=0 write must not consume a slot.
    do_reset();
    step("nf_we_nocs", 1'b0, 1'b1, 64'h3000, 12'h0AA, 1'b0, 12'h000, 1'b0);
    step("nf_look", 1'b1, 1'b0, 64'h3000, 12'h000, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step($sformatf("nf_fill%0d", i), 1'b1, 1'b1, 64'h5000 + 64'(i),
           12'h200 + 12'(i), 1'b0, 12'h000, 1'b0);
    end
    step("nf_last", 1'b1, 1'b1, 64'h5007, 12'h207, 1'b0, 12'h000, 1'b1);
    step("nf_hit", 1'b1, 1'b0, 64'h5007, 12'h000, 1'b1, 12'h207, 1'b1);

    // Asynchronous reset mid-cycle while full with match high.
    #2;
    rst = 1'b0;
    #1;
    chk("arst.match", {63'd0, match}, 64'd0);
    chk("arst.hash", {52'd0, hash_out}, 64'd0);
    chk("arst.full", {63'd0, ct_full}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 1'b1, 1'b0, 64'h5007, 12'h000, 1'b0, 12'h000, 1'b0);
    step("post_rst0", 1'b1, 1'b0, 64'h5000, 12'h000, 1'b0, 12'h000, 1'b0);

    chk("sb.empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lzw_conflict_table.md
Name: lzw_conflict_table

Overview:
- Small fully-associative lookup table for the LZW compressor core.
- Records strings whose dictionary hash collided and were relocated in RAM, keyed by the 64-bit string value, and returns the relocated address.
- Core asserts cs with the current string on data; a registered match and hash_out come back one clock later.
- On a collision the core writes the string plus its relocated address.

Parameters:
- DEPTH, 8, number of table entries (must be ≥1).
- DATA_WIDTH, 64, width of the stored string key.
- HASH_WIDTH, 12, width of the stored RAM address (hash).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset, asynchronous, active-low; clears the whole table.
- cs, input, 1, chip select; enables a lookup and/or write this cycle.
- we, input, 1, write enable; qualified by cs.
- data, input, DATA_WIDTH, string key for lookup and write.
- hash_in, input, HASH_WIDTH, address to store with data on a write.
- match, output, 1, registered; 1 when the last lookup hit a valid entry.
- hash_out, output, HASH_WIDTH, registered; stored address of the hit entry.
- ct_full, output, 1, registered; 1 when all DEPTH entries are valid.

Behaviour:
- Storage: DEPTH entries, each {valid, key[DATA_WIDTH], hash[HASH_WIDTH]}.
  - Write pointer wptr and occupancy count, width ceil(log2(DEPTH+1)).
- Reset (rst=0, asynchronous):
  - All valid bits, wptr and count cleared.
  - match=0, hash_out=0, ct_full=0.
  - Applies immediately mid-operation and overrides any write in progress.
- Lookup (every rising edge with cs=1):
  - hit = any valid entry with key==data, compared against contents before this edge's write.
  - match <= hit.
  - hash_out <= hash of the lowest-index hitting entry; unchanged on a miss.
  - Latency: one clock from cs/data sampled to match/hash_out valid.
- cs=0 at an edge: match <= 0; hash_out holds; table unchanged.
- Write (edge with cs=1 and we=1):
  - Key already present in a valid entry: that entry's hash <= hash_in. No new slot, count unchanged.
  - Else, if not full: entry[wptr] <= {1, data, hash_in}; wptr increments; count increments.
  - Else (full, new key): write silently dropped; contents unchanged.
- we=1 with cs=0: ignored.
- ct_full <= (count after this edge == DEPTH). It is set on the same edge that fills the last slot.
- No deletion or aging. The table only empties on reset. wptr never wraps because writes stop at full.
- Key 0 is a legal key; only valid entries can match.
- Simultaneous lookup and write of the same new key:
  - match=0 that cycle (pre-write contents).
  - The next lookup of that key returns match=1, hash_out=hash_in.

Test Plan:
- Reset then lookup data=64'h41 → next cycle match=0, hash_out=0, ct_full=0.
- Write data=64'h4142, hash_in=12'h1A3; then lookup 64'h4142 → match=1, hash_out=12'h1A3; lookup 64'h4143 → match=0, hash_out stays 12'h1A3.
- Write 64'h4142 again with hash_in=12'h2B0 → count unchanged; lookup returns 12'h2B0.
- Write 8 distinct keys k0..k7 with hashes 12'h100..12'h107:
  - ct_full=1 after the 8th write edge.
  - A 9th new key write is dropped; its lookup gives match=0.
  - Lookup of k7 → 12'h107.
- cs=0, we=1 with a new key, then lookup → match=0. match is 0 on any cycle following cs=0.
- Assert rst low asynchronously mid-stream while full → match, hash_out, ct_full go 0 immediately. Prior keys no longer match after rst returns high.
